// File: rtl/uart_msg_dispatcher_if.sv
// rtl/uart_msg_dispatcher_if.sv - byte input strobe and replace-request handshake bundle
interface uart_msg_dispatcher_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        repl_valid;
   logic [15:0] repl_addr;
   logic [31:0] repl_data;
   logic        repl_ready;

   modport master (
      input  rx_data, rx_valid, repl_ready,
      output repl_valid, repl_addr, repl_data
   );

   modport slave (
      output rx_data, rx_valid, repl_ready,
      input  repl_valid, repl_addr, repl_data
   );
endinterface

// File: rtl/uart_msg_dispatcher.sv
// rtl/uart_msg_dispatcher.sv - assembles 8-byte UART messages and drives config, run and replace requests
module uart_msg_dispatcher #(
   parameter int TIMEOUT_CLKS    = 81000,
   parameter int DEF_NO_NUMS     = 16,
   parameter int DEF_PULSE_WIDTH = 73,
   parameter int DEF_PULSE_GAP   = 81,
   parameter int DEF_HALF_PERIOD = 3,
   parameter int DEF_DEMOD_WIDTH = 121
) (
   input  logic                  clk,
   input  logic                  n_reset,
   uart_msg_dispatcher_if.master bus,
   output logic [15:0]           mem_no_nums,
   output logic                  mem_test_mode,
   output logic [7:0]            mem_pulse_width,
   output logic [7:0]            mem_pulse_gap,
   output logic [7:0]            mod_half_period,
   output logic [15:0]           demod_pulse_width,
   output logic                  run,
   output logic [2:0]            err,
   output logic [15:0]           msg_count
);

   localparam int TW = $clog2(TIMEOUT_CLKS + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_DECODE
   } state_t;

   state_t        state;
   logic [2:0]    byte_cnt;
   logic [TW-1:0] tmo_cnt;
   logic [63:0]   msg;

   // Bytes shift in from the top so that after eight strobes byte k sits at msg[8k+7:8k].
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state             <= S_IDLE;
         byte_cnt          <= '0;
         tmo_cnt           <= '0;
         msg               <= '0;
         mem_no_nums       <= 16'(DEF_NO_NUMS);
         mem_test_mode     <= 1'b0;
         mem_pulse_width   <= 8'(DEF_PULSE_WIDTH);
         mem_pulse_gap     <= 8'(DEF_PULSE_GAP);
         mod_half_period   <= 8'(DEF_HALF_PERIOD);
         demod_pulse_width <= 16'(DEF_DEMOD_WIDTH);
         run               <= 1'b0;
         err               <= '0;
         msg_count         <= '0;
         bus.repl_valid    <= 1'b0;
         bus.repl_addr     <= '0;
         bus.repl_data     <= '0;
      end else begin
         if (bus.repl_valid && bus.repl_ready)
            bus.repl_valid <= 1'b0;

         case (state)
            S_IDLE: begin
               if (bus.rx_valid) begin
                  msg      <= {bus.rx_data, msg[63:8]};
                  byte_cnt <= 3'd1;
                  tmo_cnt  <= '0;
                  state    <= S_COLLECT;
               end
            end

            S_COLLECT: begin
               if (bus.rx_valid) begin
                  msg     <= {bus.rx_data, msg[63:8]};
                  tmo_cnt <= '0;
                  if (byte_cnt == 3'd7) begin
                     byte_cnt <= '0;
                     state    <= S_DECODE;
                  end else begin
                     byte_cnt <= byte_cnt + 3'd1;
                  end
               end else if (tmo_cnt >= TW'(TIMEOUT_CLKS - 1)) begin
                  byte_cnt <= '0;
                  tmo_cnt  <= '0;
                  state    <= S_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            S_DECODE: begin
               msg_count <= msg_count + 16'd1;
               case (msg[63:56])
                  8'h01: begin
                     run <= msg[0];
                     if (msg[1])
                        err <= '0;
                  end
                  8'h02: begin
                     if (run) begin
                        err[2] <= 1'b1;
                     end else begin
                        mem_no_nums     <= msg[15:0];
                        mem_test_mode   <= msg[16];
                        mem_pulse_width <= msg[31:24];
                        mem_pulse_gap   <= msg[39:32];
                     end
                  end
                  8'h03: begin
                     if (run)
                        err[2] <= 1'b1;
                     else
                        mod_half_period <= msg[7:0];
                  end
                  8'h04: begin
                     if (run)
                        err[2] <= 1'b1;
                     else
                        demod_pulse_width <= msg[15:0];
                  end
                  8'h05: begin
                     // A pending request completing this edge frees the slot for the new one.
                     if (!bus.repl_valid || bus.repl_ready) begin
                        bus.repl_addr  <= msg[15:0];
                        bus.repl_data  <= msg[47:16];
                        bus.repl_valid <= 1'b1;
                     end else begin
                        err[1] <= 1'b1;
                     end
                  end
                  default: err[0] <= 1'b1;
               endcase

               // A byte landing in the decode cycle starts the next message.
               if (bus.rx_valid) begin
                  msg      <= {bus.rx_data, msg[63:8]};
                  byte_cnt <= 3'd1;
                  tmo_cnt  <= '0;
                  state    <= S_COLLECT;
               end else begin
                  byte_cnt <= '0;
                  tmo_cnt  <= '0;
                  state    <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_msg_dispatcher.sv
// tb/tb_uart_msg_dispatcher.sv - scoreboard bench for uart_msg_dispatcher
module tb_uart_msg_dispatcher;
   localparam int TMO = 40;

   logic        clk = 1'b0;
   logic        n_reset;
   logic [15:0] mem_no_nums;
   logic        mem_test_mode;
   logic [7:0]  mem_pulse_width;
   logic [7:0]  mem_pulse_gap;
   logic [7:0]  mod_half_period;
   logic [15:0] demod_pulse_width;
   logic        run;
   logic [2:0]  err;
   logic [15:0] msg_count;

   uart_msg_dispatcher_if bus();

   uart_msg_dispatcher #(.TIMEOUT_CLKS(TMO)) dut (
      .clk               (clk),
      .n_reset           (n_reset),
      .bus               (bus.master),
      .mem_no_nums       (mem_no_nums),
      .mem_test_mode     (mem_test_mode),
      .mem_pulse_width   (mem_pulse_width),
      .mem_pulse_gap     (mem_pulse_gap),
      .mod_half_period   (mod_half_period),
      .demod_pulse_width (demod_pulse_width),
      .run               (run),
      .err               (err),
      .msg_count         (msg_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [15:0] cnt;
      logic [15:0] no_nums;
      logic        test_mode;
      logic [7:0]  pw;
      logic [7:0]  gap;
      logic [7:0]  hp;
      logic [15:0] demod;
      logic        run;
      logic [2:0]  err;
   } exp_t;

   typedef struct {
      logic [15:0] addr;
      logic [31:0] data;
   } rep_t;

   exp_t exp_q[$];
   rep_t rep_q[$];

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   bit mon_en = 0;
   bit expect_reset = 0;

   logic [15:0] m_no_nums, m_demod, m_count;
   logic        m_test_mode, m_run, m_pend;
   logic [7:0]  m_pw, m_gap, m_hp;
   logic [2:0]  m_err;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      n_chk++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, want);
      end
   endtask

   task automatic model_reset();
      m_no_nums = 16; m_test_mode = 0; m_pw = 73; m_gap = 81; m_hp = 3;
      m_demod = 121; m_run = 0; m_err = 0; m_count = 0; m_pend = 0;
   endtask

   task automatic check_state();
      chk("no_nums", mem_no_nums, m_no_nums);
      chk("test_mode", mem_test_mode, m_test_mode);
      chk("pulse_width", mem_pulse_width, m_pw);
      chk("pulse_gap", mem_pulse_gap, m_gap);
      chk("half_period", mod_half_period, m_hp);
      chk("demod_width", demod_pulse_width, m_demod);
      chk("run", run, m_run);
      chk("err", err, m_err);
      chk("msg_count", msg_count, m_count);
      chk("repl_valid_idle", bus.repl_valid, 1'b0);
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_msg(input logic [7:0] hdr, input logic [55:0] p);
      logic [63:0] m;
      exp_t e;
      m = {hdr, p};
      for (int k = 0; k < 8; k++) send_byte(m[8*k +: 8]);
      case (hdr)
         8'h01: begin m_run = p[0]; if (p[1]) m_err = 0; end
         8'h02: if (m_run) m_err[2] = 1;
                else begin m_no_nums = p[15:0]; m_test_mode = p[16]; m_pw = p[31:24]; m_gap = p[39:32]; end
         8'h03: if (m_run) m_err[2] = 1; else m_hp = p[7:0];
         8'h04: if (m_run) m_err[2] = 1; else m_demod = p[15:0];
         8'h05: if (m_pend && !bus.repl_ready) m_err[1] = 1;
                else begin rep_q.push_back('{p[15:0], p[47:16]}); m_pend = !bus.repl_ready; end
         default: m_err[0] = 1;
      endcase
      m_count = m_count + 16'd1;
      e.cyc = cyc + 1; e.cnt = m_count; e.no_nums = m_no_nums; e.test_mode = m_test_mode;
      e.pw = m_pw; e.gap = m_gap; e.hp = m_hp; e.demod = m_demod; e.run = m_run; e.err = m_err;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_q.size() != 0 || rep_q.size() != 0) && t < 50) begin
         @(posedge clk);
         t++;
      end
      #1;
      chk("drain_msgs", exp_q.size(), 0);
      chk("drain_repl", rep_q.size(), 0);
   endtask

   logic [15:0] prev_count;
   logic        prev_valid, prev_xfer;
   logic [15:0] prev_addr;
   logic [31:0] prev_data;

   always @(negedge clk) begin
      if (mon_en) begin
         if (msg_count !== prev_count) begin
            if (expect_reset) begin
               chk("reset_count", msg_count, 0);
               expect_reset = 0;
            end else if (exp_q.size() == 0) begin
               chk("unexpected_msg", msg_count, prev_count);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("msg_cycle", cyc, e.cyc);
               chk("msg_count", msg_count, e.cnt);
               chk("no_nums", mem_no_nums, e.no_nums);
               chk("test_mode", mem_test_mode, e.test_mode);
               chk("pulse_width", mem_pulse_width, e.pw);
               chk("pulse_gap", mem_pulse_gap, e.gap);
               chk("half_period", mod_half_period, e.hp);
               chk("demod_width", demod_pulse_width, e.demod);
               chk("run", run, e.run);
               chk("err", err, e.err);
            end
            prev_count = msg_count;
         end
         if (prev_valid && !prev_xfer && bus.repl_valid) begin
            chk("repl_addr_stable", bus.repl_addr, prev_addr);
            chk("repl_data_stable", bus.repl_data, prev_data);
         end
         if (bus.repl_valid && bus.repl_ready) begin
            if (rep_q.size() == 0) begin
               chk("unexpected_repl", 1, 0);
            end else begin
               rep_t r;
               r = rep_q.pop_front();
               chk("repl_addr", bus.repl_addr, r.addr);
               chk("repl_data", bus.repl_data, r.data);
            end
         end
         prev_valid = bus.repl_valid;
         prev_xfer  = bus.repl_valid && bus.repl_ready;
         prev_addr  = bus.repl_addr;
         prev_data  = bus.repl_data;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_reset = 1'b0;
      bus.rx_data = '0;
      bus.rx_valid = 1'b0;
      bus.repl_ready = 1'b0;
      prev_valid = 0; prev_xfer = 0; prev_addr = 0; prev_data = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_reset = 1'b1;
      check_state();
      prev_count = 16'd0;
      mon_en = 1;

      // Back-to-back: each message's byte 0 lands in the previous decode cycle.
      send_msg(8'h02, (56'd60 << 32) | (56'd50 << 24) | 56'd32);
      send_msg(8'h03, 56'd5);
      send_msg(8'h04, 56'd200);
      send_msg(8'h01, 56'd1);
      drain();
      chk("count_after_four", msg_count, 16'd4);

      send_msg(8'h03, 56'd9);
      drain();
      send_msg(8'h01, 56'd3);
      drain();

      send_msg(8'h05, (56'd1 << 16) | 56'd1);
      repeat (10) @(posedge clk);
      #1;
      chk("repl_held", bus.repl_valid, 1'b1);
      send_msg(8'h05, 56'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("repl_retained_addr", bus.repl_addr, 16'd1);
      chk("repl_retained_data", bus.repl_data, 32'd1);
      bus.repl_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.repl_ready = 1'b0;
      m_pend = 0;
      chk("repl_done", bus.repl_valid, 1'b0);
      drain();

      bus.repl_ready = 1'b1;
      send_msg(8'h05, (56'hDEADBEEF << 16) | 56'h1234);
      drain();
      bus.repl_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("repl_idle_after_fast", bus.repl_valid, 1'b0);

      send_msg(8'h7E, 56'h00_1122_3344_5566);
      drain();
      send_msg(8'h01, 56'd2);
      drain();

      send_msg(8'h02, (56'd0 << 32) | (56'd255 << 24) | (56'd1 << 16) | 56'hFFFF);
      drain();

      send_byte(8'h07);
      send_byte(8'h00);
      send_byte(8'h00);
      repeat (TMO + 1) @(posedge clk);
      #1;
      send_msg(8'h03, 56'd7);
      drain();
      chk("timeout_no_err", err, 3'd0);

      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h44);
      send_byte(8'h55);
      expect_reset = 1;
      n_reset = 1'b0;
      @(posedge clk);
      #1;
      n_reset = 1'b1;
      model_reset();
      check_state();
      send_msg(8'h04, 56'd99);
      drain();
      chk("demod_final", demod_pulse_width, 16'd99);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_msg_dispatcher.md
Name: uart_msg_dispatcher

Overview:
- Sits between the UART receiver and the delay-line datapath in the test harness.
- Assembles 8 received bytes, LSB byte first, into one 64-bit message and decodes its header.
- Drives the configuration registers of the memory manager, modulator and demodulator, plus the run flag.
- Issues replace-number requests to the memory manager over a valid/ready handshake; tracks resync timeout and sticky error flags.

Parameters:
- TIMEOUT_CLKS, 81000, max clocks between bytes of one message before the partial message is discarded (1 ms at 81 MHz)
- DEF_NO_NUMS, 16, reset value of mem_no_nums
- DEF_PULSE_WIDTH, 73, reset value of mem_pulse_width
- DEF_PULSE_GAP, 81, reset value of mem_pulse_gap
- DEF_HALF_PERIOD, 3, reset value of mod_half_period
- DEF_DEMOD_WIDTH, 121, reset value of demod_pulse_width

Ports:
- clk  in  1  system clock
- n_reset  in  1  synchronous active-low reset
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  one-cycle strobe, rx_data valid
- mem_no_nums  out  16  numbers in delay line
- mem_test_mode  out  1  memory manager test mode
- mem_pulse_width  out  8  pulse width in clocks
- mem_pulse_gap  out  8  pulse gap in clocks
- mod_half_period  out  8  modulator cycles per half period
- demod_pulse_width  out  16  demodulator pulse width threshold
- run  out  1  system running
- repl_valid  out  1  replace request pending
- repl_addr  out  16  replace address
- repl_data  out  32  replace data
- repl_ready  in  1  memory manager accepts replace
- err  out  3  sticky: [0] unknown header, [1] replace dropped, [2] config write while running
- msg_count  out  16  wrapping count of complete messages decoded

Behaviour:
- Message layout: header = msg[63:56], payload = msg[55:0]; byte k received goes to msg[8k+7:8k].
- Header codes:
  - 0x01 SYS_STATUS: run = p[0]; p[1]=1 clears err.
  - 0x02 MEM_PARAMS: no_nums = p[15:0], test_mode = p[16], pulse_width = p[31:24], pulse_gap = p[39:32].
  - 0x03 MOD_PARAMS: half_period = p[7:0].
  - 0x04 DEMOD_PARAMS: width = p[15:0].
  - 0x05 REPLACE_NUM: addr = p[15:0], data = p[47:16].
- Reset (n_reset low at a clk edge):
  - Config outputs take their DEF_ parameter values; mem_test_mode = 0.
  - run = 0, repl_valid = 0, repl_addr = 0, repl_data = 0, err = 0, msg_count = 0.
  - Byte counter and timeout counter cleared; any partial message or pending replace is discarded.
- Assembler states:
  - IDLE: byte count 0. rx_valid stores byte 0 and moves to COLLECT.
  - COLLECT: each rx_valid stores the next byte. When the 8th byte is sampled at edge N, go to DECODE.
  - DECODE: lasts one cycle; applies the message at edge N+1, increments msg_count (wraps at 65535 to 0), and returns to IDLE.
- A byte arriving during DECODE is byte 0 of the next message. It is captured and the state goes to COLLECT with count 1; no byte is ever lost.
- Timeout: the counter runs in COLLECT and resets on each rx_valid. When it reaches TIMEOUT_CLKS, return to IDLE with count 0 and discard the partial message. No error flag is set for a timeout.
- MEM, MOD and DEMOD messages received while run = 1 are ignored and set err[2]. SYS_STATUS is always applied.
- REPLACE_NUM handling:
  - If repl_valid = 0, load repl_addr/repl_data and set repl_valid at edge N+1.
  - If repl_valid = 1 and repl_ready is low in the DECODE cycle, drop the new request and set err[1].
  - If repl_ready is high in the DECODE cycle, the old request completes and the new one loads, so repl_valid stays 1.
  - Replace is accepted regardless of run.
- Handshake:
  - Transfer completes on an edge with repl_valid & repl_ready; repl_valid falls the following cycle unless a new request is reloaded.
  - repl_addr and repl_data are stable while repl_valid is high.
- An unknown header sets err[0]; msg_count still increments.
- err bits are sticky until reset or a SYS_STATUS message with p[1]=1. A clear and a new error in the same message (not possible by encoding) need no handling; a new error in a later message sets the bit again.
- Config and run outputs are registered, glitch-free, and change only at edge N+1.

Test Plan:
- Reset, then check idle outputs -> no_nums=16, pulse_width=73, gap=81, half_period=3, demod=121, run=0, err=0, repl_valid=0.
- Send MEM_PARAMS (no_nums=32, width=50, gap=60), MOD (5), DEMOD (200), then SYS_STATUS p=1 -> each output updates exactly 1 clock after its 8th byte strobe; run=1; msg_count=4.
- With run=1, send MOD_PARAMS half_period=9 -> half_period stays 5 and err[2]=1. Then send SYS_STATUS p=0x3 -> err=0 and run=1.
- REPLACE addr=1 data=1 with repl_ready held low 10 clocks -> repl_valid high and stable. Send a second REPLACE addr=1 data=0 -> err[1]=1 and the first request is retained. Raise repl_ready -> one transfer, then repl_valid=0.
- Send 3 bytes, idle TIMEOUT_CLKS+1 clocks, then a full 8-byte MOD_PARAMS=7 -> half_period=7, msg_count increments by 1 only, no error.
- Assert n_reset for 1 cycle after the 5th byte of a message, then send a full DEMOD message=99 -> partial message discarded, outputs at defaults, then demod_pulse_width=99.
